// File: rtl/writeback_arbiter.sv
// writeback_arbiter
//
// Merges results from three execution units (am, mem, mul) onto the single
// register-file write port and the scoreboard pending-clear port.
//
// Each unit owns a one-entry holding slot. An offer is taken into the slot on
// an edge where u_wb_valid && u_wb_ready, and u_wb_ready is simply the
// inverse of the slot's full bit. Every cycle, one full slot is granted by
// round-robin starting at rr_ptr (am -> mem -> mul -> am). On the edge that
// ends the grant cycle:
//   - the granted slot is freed;
//   - rr_ptr moves to the unit after the granted one;
//   - the write-port and scoreboard outputs are registered.
// Register 0 is never written or released, and neither is a result with
// writereg = 0. Either way the grant still frees the slot and still updates
// addr/data/unit.
//
// Handshake: an offer transfers on a rising edge where valid && ready.
// ready depends only on slot state, never on valid. While ready is low, the
// unit must hold its offer, and the arbiter ignores it.
//
// Ports
//   clock, reset            system clock; synchronous active-high reset
//   <u>_wb_valid            unit u offers a result          (u = am/mem/mul)
//   <u>_wb_regdest[4:0]     destination register of the offer
//   <u>_wb_data[31:0]       result value of the offer
//   <u>_wb_writereg         offer must be written to the register file
//   <u>_wb_ready            unit u's holding slot is empty
//   wb_reg_addr/data/write  register-file write port (registered)
//   wb_sb_addr/release      scoreboard pending-clear port (registered)
//   wb_sb_unit[1:0]         granted unit: 00 am, 01 mem, 10 mul
//   wb_busy                 at least one holding slot is full
module writeback_arbiter (
  input  logic        clock,
  input  logic        reset,
  input  logic        am_wb_valid,
  input  logic [4:0]  am_wb_regdest,
  input  logic [31:0] am_wb_data,
  input  logic        am_wb_writereg,
  output logic        am_wb_ready,
  input  logic        mem_wb_valid,
  input  logic [4:0]  mem_wb_regdest,
  input  logic [31:0] mem_wb_data,
  input  logic        mem_wb_writereg,
  output logic        mem_wb_ready,
  input  logic        mul_wb_valid,
  input  logic [4:0]  mul_wb_regdest,
  input  logic [31:0] mul_wb_data,
  input  logic        mul_wb_writereg,
  output logic        mul_wb_ready,
  output logic [4:0]  wb_reg_addr,
  output logic [31:0] wb_reg_data,
  output logic        wb_reg_write,
  output logic [4:0]  wb_sb_addr,
  output logic        wb_sb_release,
  output logic [1:0]  wb_sb_unit,
  output logic        wb_busy
);

  localparam logic [1:0] UNIT_AM  = 2'd0;
  localparam logic [1:0] UNIT_MEM = 2'd1;
  localparam logic [1:0] UNIT_MUL = 2'd2;

  // Holding slots, indexed by unit code.
  logic [2:0]  full_q;
  logic [2:0]  writereg_q;
  logic [4:0]  regdest_q [3];
  logic [31:0] data_q    [3];
  logic [1:0]  rr_ptr;

  // Unit inputs gathered into unit-code-indexed vectors.
  logic [2:0]  in_valid;
  logic [2:0]  in_writereg;
  logic [4:0]  in_regdest [3];
  logic [31:0] in_data    [3];
  logic [2:0]  accept;

  assign in_valid      = {mul_wb_valid, mem_wb_valid, am_wb_valid};
  assign in_writereg   = {mul_wb_writereg, mem_wb_writereg, am_wb_writereg};
  assign in_regdest[0] = am_wb_regdest;
  assign in_regdest[1] = mem_wb_regdest;
  assign in_regdest[2] = mul_wb_regdest;
  assign in_data[0]    = am_wb_data;
  assign in_data[1]    = mem_wb_data;
  assign in_data[2]    = mul_wb_data;

  // A slot that is being granted this cycle is still full. So it cannot
  // accept on the same edge, and its ready rises only after the grant edge.
  assign accept = in_valid & ~full_q;

  assign am_wb_ready  = ~full_q[0];
  assign mem_wb_ready = ~full_q[1];
  assign mul_wb_ready = ~full_q[2];
  assign wb_busy      = |full_q;

  function automatic logic [1:0] next_unit(input logic [1:0] u);
    case (u)
      UNIT_AM:  return UNIT_MEM;
      UNIT_MEM: return UNIT_MUL;
      default:  return UNIT_AM;
    endcase
  endfunction

  function automatic logic slot_full(input logic [2:0] f, input logic [1:0] u);
    case (u)
      UNIT_AM:  return f[0];
      UNIT_MEM: return f[1];
      UNIT_MUL: return f[2];
      default:  return 1'b0;
    endcase
  endfunction

  // Round-robin grant: first full slot at or after rr_ptr.
  logic [1:0]  cand1, cand2;
  logic        gnt_valid;
  logic [1:0]  gnt_unit;
  logic [2:0]  gnt_onehot;
  logic [4:0]  gnt_regdest;
  logic [31:0] gnt_data;
  logic        gnt_writereg;
  logic        gnt_commit;

  always_comb begin
    cand1     = next_unit(rr_ptr);
    cand2     = next_unit(cand1);
    gnt_valid = 1'b1;
    gnt_unit  = rr_ptr;
    if (slot_full(full_q, rr_ptr)) begin
      gnt_unit = rr_ptr;
    end else if (slot_full(full_q, cand1)) begin
      gnt_unit = cand1;
    end else if (slot_full(full_q, cand2)) begin
      gnt_unit = cand2;
    end else begin
      gnt_valid = 1'b0;
    end
  end

  always_comb begin
    gnt_regdest  = regdest_q[0];
    gnt_data     = data_q[0];
    gnt_writereg = writereg_q[0];
    case (gnt_unit)
      UNIT_MEM: begin
        gnt_regdest  = regdest_q[1];
        gnt_data     = data_q[1];
        gnt_writereg = writereg_q[1];
      end
      UNIT_MUL: begin
        gnt_regdest  = regdest_q[2];
        gnt_data     = data_q[2];
        gnt_writereg = writereg_q[2];
      end
      default: begin
      end
    endcase
  end

  assign gnt_onehot = gnt_valid ? (3'b001 << gnt_unit) : 3'b000;
  // Register 0 is hard-wired, so it is never reserved in the scoreboard.
  assign gnt_commit = gnt_valid && gnt_writereg && (gnt_regdest != 5'd0);

  always_ff @(posedge clock) begin
    if (reset) begin
      full_q        <= 3'b000;
      rr_ptr        <= UNIT_AM;
      wb_reg_write  <= 1'b0;
      wb_sb_release <= 1'b0;
      wb_reg_addr   <= 5'd0;
      wb_reg_data   <= 32'd0;
      wb_sb_addr    <= 5'd0;
      wb_sb_unit    <= UNIT_AM;
    end else begin
      full_q        <= (full_q & ~gnt_onehot) | accept;
      wb_reg_write  <= gnt_commit;
      wb_sb_release <= gnt_commit;
      // rr_ptr holds when idle; addr/data/unit hold when there is no grant.
      if (gnt_valid) begin
        rr_ptr      <= next_unit(gnt_unit);
        wb_reg_addr <= gnt_regdest;
        wb_sb_addr  <= gnt_regdest;
        wb_reg_data <= gnt_data;
        wb_sb_unit  <= gnt_unit;
      end
    end
  end

  // Slot payload needs no reset: it is only consumed while full is set.
  always_ff @(posedge clock) begin
    for (int u = 0; u < 3; u++) begin
      if (accept[u]) begin
        regdest_q[u]  <= in_regdest[u];
        data_q[u]     <= in_data[u];
        writereg_q[u] <= in_writereg[u];
      end
    end
  end

endmodule

// File: tb/tb_writeback_arbiter.sv
// Self-checking bench for writeback_arbiter. It runs directed scenarios with
// literal expectations, then a randomized run. Every cycle, the DUT is
// compared against a behavioural model of the slots and round-robin rules.
module tb_writeback_arbiter;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic        am_wb_valid, mem_wb_valid, mul_wb_valid;
  logic [4:0]  am_wb_regdest, mem_wb_regdest, mul_wb_regdest;
  logic [31:0] am_wb_data, mem_wb_data, mul_wb_data;
  logic        am_wb_writereg, mem_wb_writereg, mul_wb_writereg;
  logic        am_wb_ready, mem_wb_ready, mul_wb_ready;
  logic [4:0]  wb_reg_addr, wb_sb_addr;
  logic [31:0] wb_reg_data;
  logic        wb_reg_write, wb_sb_release, wb_busy;
  logic [1:0]  wb_sb_unit;

  writeback_arbiter dut (
    .clock(clock), .reset(reset),
    .am_wb_valid(am_wb_valid), .am_wb_regdest(am_wb_regdest),
    .am_wb_data(am_wb_data), .am_wb_writereg(am_wb_writereg), .am_wb_ready(am_wb_ready),
    .mem_wb_valid(mem_wb_valid), .mem_wb_regdest(mem_wb_regdest),
    .mem_wb_data(mem_wb_data), .mem_wb_writereg(mem_wb_writereg), .mem_wb_ready(mem_wb_ready),
    .mul_wb_valid(mul_wb_valid), .mul_wb_regdest(mul_wb_regdest),
    .mul_wb_data(mul_wb_data), .mul_wb_writereg(mul_wb_writereg), .mul_wb_ready(mul_wb_ready),
    .wb_reg_addr(wb_reg_addr), .wb_reg_data(wb_reg_data), .wb_reg_write(wb_reg_write),
    .wb_sb_addr(wb_sb_addr), .wb_sb_release(wb_sb_release), .wb_sb_unit(wb_sb_unit),
    .wb_busy(wb_busy)
  );

  int   vectors     = 0;
  int   miscompares = 0;
  logic check_en    = 1'b0;

  task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          m_full [3];
  logic [4:0]  m_rd   [3];
  logic [31:0] m_data [3];
  bit          m_wr   [3];
  int          m_ptr;
  logic [4:0]  e_addr;
  logic [31:0] e_data;
  logic [1:0]  e_unit;
  logic        e_write;
  logic [36:0] exp_q [$];

  always @(posedge clock) begin
    bit          v    [3];
    bit          old  [3];
    logic [4:0]  rd   [3];
    logic [31:0] dat  [3];
    bit          wr   [3];
    int          g;
    v   = '{am_wb_valid, mem_wb_valid, mul_wb_valid};
    rd  = '{am_wb_regdest, mem_wb_regdest, mul_wb_regdest};
    dat = '{am_wb_data, mem_wb_data, mul_wb_data};
    wr  = '{am_wb_writereg, mem_wb_writereg, mul_wb_writereg};
    if (reset) begin
      m_full  = '{0, 0, 0};
      m_ptr   = 0;
      e_addr  = 5'd0;
      e_data  = 32'd0;
      e_unit  = 2'd0;
      e_write = 1'b0;
      exp_q.delete();
    end else begin
      old = m_full;
      g   = -1;
      for (int k = 0; k < 3; k++)
        if (g < 0 && old[(m_ptr + k) % 3]) g = (m_ptr + k) % 3;
      e_write = 1'b0;
      if (g >= 0) begin
        e_addr  = m_rd[g];
        e_data  = m_data[g];
        e_unit  = 2'(g);
        e_write = m_wr[g] && (m_rd[g] != 5'd0);
        m_full[g] = 0;
        m_ptr   = (g + 1) % 3;
        if (e_write) exp_q.push_back({e_addr, e_data});
      end
      for (int u = 0; u < 3; u++) begin
        if (v[u] && !old[u]) begin
          m_full[u] = 1;
          m_rd[u]   = rd[u];
          m_data[u] = dat[u];
          m_wr[u]   = wr[u];
        end
      end
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clock) begin
    logic [36:0] item;
    if (check_en) begin
      chk("am_ready",   am_wb_ready,   !m_full[0]);
      chk("mem_ready",  mem_wb_ready,  !m_full[1]);
      chk("mul_ready",  mul_wb_ready,  !m_full[2]);
      chk("busy",       wb_busy,       m_full[0] || m_full[1] || m_full[2]);
      chk("reg_write",  wb_reg_write,  e_write);
      chk("sb_release", wb_sb_release, e_write);
      chk("reg_addr",   wb_reg_addr,   e_addr);
      chk("sb_addr",    wb_sb_addr,    e_addr);
      chk("reg_data",   wb_reg_data,   e_data);
      chk("sb_unit",    wb_sb_unit,    e_unit);
      if (wb_reg_write) begin
        if (exp_q.size() == 0) begin
          chk("sb_queue_nonempty", exp_q.size(), 1);
        end else begin
          item = exp_q.pop_front();
          chk("sb_write", {wb_reg_addr, wb_reg_data}, item);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle();
    am_wb_valid = 1'b0; mem_wb_valid = 1'b0; mul_wb_valid = 1'b0;
  endtask

  task automatic offer(input int u, input logic [4:0] rd, input logic [31:0] d, input logic wr);
    case (u)
      0: begin am_wb_valid = 1'b1;  am_wb_regdest = rd;  am_wb_data = d;  am_wb_writereg = wr;  end
      1: begin mem_wb_valid = 1'b1; mem_wb_regdest = rd; mem_wb_data = d; mem_wb_writereg = wr; end
      default: begin mul_wb_valid = 1'b1; mul_wb_regdest = rd; mul_wb_data = d; mul_wb_writereg = wr; end
    endcase
  endtask

  // One rising edge, then return at the following falling edge.
  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic chk_grant(input string name, input logic wr, input logic [4:0] a,
                           input logic [31:0] d, input logic [1:0] u);
    chk({name, "_write"},   wb_reg_write,  wr);
    chk({name, "_release"}, wb_sb_release, wr);
    chk({name, "_addr"},    wb_reg_addr,   a);
    chk({name, "_sbaddr"},  wb_sb_addr,    a);
    chk({name, "_data"},    wb_reg_data,   d);
    chk({name, "_unit"},    wb_sb_unit,    u);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    idle();
    am_wb_regdest = '0; mem_wb_regdest = '0; mul_wb_regdest = '0;
    am_wb_data = '0; mem_wb_data = '0; mul_wb_data = '0;
    am_wb_writereg = 1'b0; mem_wb_writereg = 1'b0; mul_wb_writereg = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    check_en = 1'b1;
    chk_grant("rst", 1'b0, 5'd0, 32'd0, 2'd0);
    chk("rst_ready", {am_wb_ready, mem_wb_ready, mul_wb_ready}, 3'b111);
    chk("rst_busy", wb_busy, 1'b0);

    // Three-way collision, rr_ptr = am.
    offer(0, 5'd1, 32'h11, 1'b1); offer(1, 5'd2, 32'h22, 1'b1); offer(2, 5'd3, 32'h33, 1'b1);
    step(); idle();
    chk("col_ready", {am_wb_ready, mem_wb_ready, mul_wb_ready}, 3'b000);
    chk("col_nowrite", wb_reg_write, 1'b0);
    step(); chk_grant("col1", 1'b1, 5'd1, 32'h11, 2'd0); chk("col1_busy", wb_busy, 1'b1);
    step(); chk_grant("col2", 1'b1, 5'd2, 32'h22, 2'd1); chk("col2_busy", wb_busy, 1'b1);
    step(); chk_grant("col3", 1'b1, 5'd3, 32'h33, 2'd2); chk("col3_busy", wb_busy, 1'b0);

    // Single result from am.
    offer(0, 5'd5, 32'h0000_00AA, 1'b1);
    step(); idle();
    chk("single_ready_lo", am_wb_ready, 1'b0);
    chk("single_nowrite", wb_reg_write, 1'b0);
    step(); chk_grant("single", 1'b1, 5'd5, 32'hAA, 2'd0);
    chk("single_ready_hi", am_wb_ready, 1'b1);

    // Fairness: rr_ptr = mem, am and mul full -> mul first.
    offer(0, 5'd10, 32'h1010, 1'b1); offer(2, 5'd12, 32'h1212, 1'b1);
    step(); idle();
    step(); chk_grant("fair_mul", 1'b1, 5'd12, 32'h1212, 2'd2);
    step(); chk_grant("fair_am", 1'b1, 5'd10, 32'h1010, 2'd0);

    // Register 0 and store (writereg = 0) from mem.
    offer(1, 5'd0, 32'h5, 1'b1);
    step(); idle();
    step(); chk_grant("r0", 1'b0, 5'd0, 32'h5, 2'd1);
    chk("r0_ready", mem_wb_ready, 1'b1);
    offer(1, 5'd7, 32'h7, 1'b0);
    step(); idle();
    step(); chk_grant("store", 1'b0, 5'd7, 32'h7, 2'd1);
    chk("store_ready", mem_wb_ready, 1'b1);

    // Backpressure on mul: data changes while the slot is full.
    offer(2, 5'd9, 32'h99, 1'b1);
    step(); chk("bp_ready_lo", mul_wb_ready, 1'b0);
    mul_wb_data = 32'h77;
    step(); chk_grant("bp_first", 1'b1, 5'd9, 32'h99, 2'd2);
    chk("bp_ready_hi", mul_wb_ready, 1'b1);
    step(); chk("bp_accept2", mul_wb_ready, 1'b0); chk("bp_nowrite", wb_reg_write, 1'b0);
    idle();
    step(); chk_grant("bp_second", 1'b1, 5'd9, 32'h77, 2'd2);

    // Reset mid-operation. First move rr_ptr off am, then fill every slot.
    offer(0, 5'd20, 32'h20, 1'b1);
    step(); idle();
    step(); chk_grant("pre_rst", 1'b1, 5'd20, 32'h20, 2'd0);
    offer(0, 5'd13, 32'h13, 1'b1); offer(1, 5'd14, 32'h14, 1'b1); offer(2, 5'd15, 32'h15, 1'b1);
    step(); idle();
    chk("mid_busy", wb_busy, 1'b1);
    reset = 1'b1;
    step(); reset = 1'b0;
    chk_grant("mid_rst", 1'b0, 5'd0, 32'd0, 2'd0);
    chk("mid_ready", {am_wb_ready, mem_wb_ready, mul_wb_ready}, 3'b111);
    chk("mid_busy0", wb_busy, 1'b0);
    step(); chk("mid_nowrite1", wb_reg_write, 1'b0);
    step(); chk("mid_nowrite2", wb_reg_write, 1'b0);
    offer(0, 5'd4, 32'h44, 1'b1); offer(1, 5'd6, 32'h66, 1'b1);
    step(); idle();
    step(); chk_grant("post_am", 1'b1, 5'd4, 32'h44, 2'd0);
    step(); chk_grant("post_mem", 1'b1, 5'd6, 32'h66, 2'd1);

    // Randomized traffic, with occasional resets.
    repeat (1500) begin
      am_wb_valid     = ($urandom_range(0, 3) != 0);
      mem_wb_valid    = ($urandom_range(0, 3) != 0);
      mul_wb_valid    = ($urandom_range(0, 3) != 0);
      am_wb_regdest   = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      mem_wb_regdest  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      mul_wb_regdest  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      am_wb_data      = $urandom();
      mem_wb_data     = $urandom();
      mul_wb_data     = $urandom();
      am_wb_writereg  = ($urandom_range(0, 3) != 0);
      mem_wb_writereg = ($urandom_range(0, 3) != 0);
      mul_wb_writereg = ($urandom_range(0, 3) != 0);
      reset           = ($urandom_range(0, 199) == 0);
      step();
    end
    reset = 1'b0;
    idle();
    repeat (5) step();
    chk("sb_drain", exp_q.size(), 0);

    // ---------------- report ----------------
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
